// File: rtl/snow64_instr_encoder_pkg.sv
// rtl/snow64_instr_encoder_pkg.sv - shared types, field widths and helpers for the Snow64 instruction encoder
package snow64_instr_encoder_pkg;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_BAD_GROUP = 2'd1,
        ERR_BAD_OPER  = 2'd2,
        ERR_IMM_RANGE = 2'd3
    } err_cause_t;

    typedef struct packed {
        logic [2:0]  group;
        logic        op_type;
        logic [3:0]  ra_index;
        logic [3:0]  rb_index;
        logic [3:0]  rc_index;
        logic [3:0]  oper;
        logic [63:0] imm;
    } port_in_instr_encoder_t;

    localparam int WIDTH__IOG0_SIMM = 12;
    localparam int WIDTH__IOG1_SIMM = 20;
    localparam int WIDTH__IOG2_SIMM = 12;
    localparam int WIDTH__IOG3_SIMM = 12;
    localparam int WIDTH__IOG4_SIMM = 16;

    localparam logic [3:0] LAST_GOOD_OPER_IOG0 = 4'd12;
    localparam logic [3:0] LAST_GOOD_OPER_IOG1 = 4'd11;
    localparam logic [3:0] LAST_GOOD_OPER_IOG2 = 4'd8;
    localparam logic [3:0] LAST_GOOD_OPER_IOG3 = 4'd8;
    localparam logic [3:0] LAST_GOOD_OPER_IOG4 = 4'd8;

    // Instruction word layouts, MSB first; each is exactly 32 bits wide
    typedef struct packed {
        logic [2:0]  group;
        logic        op_type;
        logic [3:0]  ra_index;
        logic [3:0]  rb_index;
        logic [3:0]  rc_index;
        logic [3:0]  oper;
        logic [11:0] simm;
    } iog0_instr_t;

    typedef struct packed {
        logic [2:0]  group;
        logic        fill;
        logic [3:0]  ra_index;
        logic [3:0]  oper;
        logic [19:0] simm;
    } iog1_instr_t;

    typedef struct packed {
        logic [2:0]  group;
        logic        fill;
        logic [3:0]  ra_index;
        logic [3:0]  rb_index;
        logic [3:0]  rc_index;
        logic [3:0]  oper;
        logic [11:0] simm;
    } iog2_instr_t;

    typedef iog2_instr_t iog3_instr_t;

    typedef struct packed {
        logic [2:0]  group;
        logic        op_type;
        logic [3:0]  ra_index;
        logic [3:0]  rb_index;
        logic [3:0]  oper;
        logic [15:0] simm;
    } iog4_instr_t;

    // True when imm is representable as an n-bit signed value (bits [63:n-1] all equal)
    function automatic logic imm_fits(input logic [63:0] imm, input int n);
        logic signed [63:0] hi;
        hi = $signed(imm) >>> (n - 1);
        return (hi == 64'sd0) || (hi == -64'sd1);
    endfunction

endpackage

// File: rtl/snow64_instr_word_fifo.sv
// rtl/snow64_instr_word_fifo.sv - 2-entry word FIFO with push/pop/flush and occupancy count
module snow64_instr_word_fifo #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign rdata   = mem[rd_ptr];

    // Storage and pointers; flush discards any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/snow64_instr_encoder.sv
// rtl/snow64_instr_encoder.sv - packs decoded fields into a 32-bit Snow64 instruction word behind a 2-entry FIFO
module snow64_instr_encoder
    import snow64_instr_encoder_pkg::*;
#(
    parameter int WIDTH__IMM_IN = 64,
    parameter int WIDTH__STAT   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_group,
    input  logic                     in_op_type,
    input  logic [3:0]               in_ra_index,
    input  logic [3:0]               in_rb_index,
    input  logic [3:0]               in_rc_index,
    input  logic [3:0]               in_oper,
    input  logic [WIDTH__IMM_IN-1:0] in_imm,
    input  logic                     in_flush,
    input  logic                     in_clr_stats,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic                     out_err,
    output err_cause_t               out_err_cause,
    output logic [WIDTH__STAT-1:0]   out_stat_encoded,
    output logic [15:0]              out_stat_errors
);

    port_in_instr_encoder_t fields;
    iog0_instr_t            g0;
    iog1_instr_t            g1;
    iog2_instr_t            g2;
    iog4_instr_t            g4;
    logic [31:0]            word;
    err_cause_t             cause;
    logic                   live;
    logic                   accept;
    logic [1:0]             count;
    logic [34:0]            head;

    assign fields = '{group: in_group, op_type: in_op_type, ra_index: in_ra_index,
                      rb_index: in_rb_index, rc_index: in_rc_index, oper: in_oper,
                      imm: 64'(in_imm)};

    assign g0 = '{group: fields.group, op_type: fields.op_type, ra_index: fields.ra_index,
                  rb_index: fields.rb_index, rc_index: fields.rc_index, oper: fields.oper,
                  simm: fields.imm[11:0]};
    assign g1 = '{group: fields.group, fill: 1'b0, ra_index: fields.ra_index,
                  oper: fields.oper, simm: fields.imm[19:0]};
    assign g2 = '{group: fields.group, fill: 1'b0, ra_index: fields.ra_index,
                  rb_index: fields.rb_index, rc_index: fields.rc_index, oper: fields.oper,
                  simm: fields.imm[11:0]};
    assign g4 = '{group: fields.group, op_type: fields.op_type, ra_index: fields.ra_index,
                  rb_index: fields.rb_index, oper: fields.oper, simm: fields.imm[15:0]};

    // Select the group layout and resolve the highest-priority encoding error
    always_comb begin
        word  = 32'(g0);
        cause = ERR_NONE;
        case (fields.group)
            3'd0: begin
                word = 32'(g0);
                if (fields.oper > LAST_GOOD_OPER_IOG0)                 cause = ERR_BAD_OPER;
                else if (!imm_fits(fields.imm, WIDTH__IOG0_SIMM))      cause = ERR_IMM_RANGE;
            end
            3'd1: begin
                word = 32'(g1);
                if (fields.oper > LAST_GOOD_OPER_IOG1)                 cause = ERR_BAD_OPER;
                else if (!imm_fits(fields.imm, WIDTH__IOG1_SIMM))      cause = ERR_IMM_RANGE;
            end
            3'd2: begin
                word = 32'(g2);
                if (fields.oper > LAST_GOOD_OPER_IOG2)                 cause = ERR_BAD_OPER;
                else if (!imm_fits(fields.imm, WIDTH__IOG2_SIMM))      cause = ERR_IMM_RANGE;
            end
            3'd3: begin
                word = 32'(iog3_instr_t'(g2));
                if (fields.oper > LAST_GOOD_OPER_IOG3)                 cause = ERR_BAD_OPER;
                else if (!imm_fits(fields.imm, WIDTH__IOG3_SIMM))      cause = ERR_IMM_RANGE;
            end
            3'd4: begin
                word = 32'(g4);
                if (fields.oper > LAST_GOOD_OPER_IOG4)                 cause = ERR_BAD_OPER;
                else if (!imm_fits(fields.imm, WIDTH__IOG4_SIMM))      cause = ERR_IMM_RANGE;
            end
            default: begin
                word  = 32'(g0);
                cause = ERR_BAD_GROUP;
            end
        endcase
    end

    assign in_ready = live && (count != 2'd2) && !in_flush;
    assign accept   = in_valid && in_ready;

    snow64_instr_word_fifo #(.WIDTH(35)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (out_valid && out_ready),
        .flush (in_flush),
        .wdata ({word, (cause != ERR_NONE), cause}),
        .rdata (head),
        .count (count)
    );

    assign out_valid     = (count != 2'd0);
    assign out_instr     = head[34:3];
    assign out_err       = head[2];
    assign out_err_cause = err_cause_t'(head[1:0]);

    // Hold in_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    // Accept counters: clear wins over increment; encoded wraps, errors saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_stat_encoded <= '0;
            out_stat_errors  <= '0;
        end else if (in_clr_stats) begin
            out_stat_encoded <= '0;
            out_stat_errors  <= '0;
        end else if (accept) begin
            out_stat_encoded <= out_stat_encoded + 1'b1;
            if ((cause != ERR_NONE) && (out_stat_errors != 16'hFFFF))
                out_stat_errors <= out_stat_errors + 16'd1;
        end
    end

endmodule

// File: tb/tb_snow64_instr_encoder.sv
// tb/tb_snow64_instr_encoder.sv - directed self-checking bench for snow64_instr_encoder
module tb_snow64_instr_encoder;
    import snow64_instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_group;
    logic        in_op_type;
    logic [3:0]  in_ra_index;
    logic [3:0]  in_rb_index;
    logic [3:0]  in_rc_index;
    logic [3:0]  in_oper;
    logic [63:0] in_imm;
    logic        in_flush;
    logic        in_clr_stats;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    err_cause_t  out_err_cause;
    logic [31:0] out_stat_encoded;
    logic [15:0] out_stat_errors;

    int n_pass  = 0;
    int n_total = 0;

    snow64_instr_encoder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_group         (in_group),
        .in_op_type       (in_op_type),
        .in_ra_index      (in_ra_index),
        .in_rb_index      (in_rb_index),
        .in_rc_index      (in_rc_index),
        .in_oper          (in_oper),
        .in_imm           (in_imm),
        .in_flush         (in_flush),
        .in_clr_stats     (in_clr_stats),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_err          (out_err),
        .out_err_cause    (out_err_cause),
        .out_stat_encoded (out_stat_encoded),
        .out_stat_errors  (out_stat_errors)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] g, input logic op, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [3:0] rc,
                              input logic [3:0] oper, input logic [63:0] imm);
        in_group    = g;
        in_op_type  = op;
        in_ra_index = ra;
        in_rb_index = rb;
        in_rc_index = rc;
        in_oper     = oper;
        in_imm      = imm;
    endtask

    // Present one bundle and wait (bounded) for it to be accepted
    task automatic send(input logic [2:0] g, input logic op, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [3:0] rc,
                        input logic [3:0] oper, input logic [63:0] imm);
        logic accepted;
        accepted = 1'b0;
        set_fields(g, op, ra, rb, rc, oper, imm);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                step();
                accepted = 1'b1;
                break;
            end
            step();
        end
        in_valid = 1'b0;
        if (!accepted) check("accept_timeout", 64'(accepted), 64'd1);
    endtask

    task automatic expect_head(input string tag, input logic [31:0] instr,
                               input logic err, input err_cause_t cause);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_instr"}, 64'(out_instr), 64'(instr));
        check({tag, "_err"},   64'(out_err), 64'(err));
        check({tag, "_cause"}, 64'(out_err_cause), 64'(cause));
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int n_acc;
        rst_n = 1'b0; in_valid = 1'b0; in_flush = 1'b0; in_clr_stats = 1'b0; out_ready = 1'b0;
        set_fields(3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0);
        #3;
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_err",   64'(out_err), 64'd0);
        check("rst_cause",     64'(out_err_cause), 64'(ERR_NONE));
        check("rst_stat_enc",  64'(out_stat_encoded), 64'd0);
        check("rst_stat_err",  64'(out_stat_errors), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // G0 three-register add
        send(3'd0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd0, 64'd0);
        expect_head("g0_add", 32'h01230000, 1'b0, ERR_NONE);
        pop_one();
        check("g0_popped", 64'(out_valid), 64'd0);

        // G1 ignores rb/rc, fill forced to zero
        send(3'd1, 1'b1, 4'd5, 4'd7, 4'd7, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        expect_head("g1_btru", 32'h250FFFFF, 1'b0, ERR_NONE);
        pop_one();

        // G4 immediate boundary
        send(3'd4, 1'b0, 4'd1, 4'd2, 4'd9, 4'd8, 64'h7FFF);
        expect_head("g4_max", 32'h81287FFF, 1'b0, ERR_NONE);
        pop_one();
        send(3'd4, 1'b0, 4'd1, 4'd2, 4'd9, 4'd8, 64'd32768);
        expect_head("g4_range", 32'h81288000, 1'b1, ERR_IMM_RANGE);
        pop_one();

        // Error priority
        send(3'd0, 1'b0, 4'd1, 4'd2, 4'd3, 4'd14, 64'd4096);
        expect_head("g0_badoper", 32'h0123E000, 1'b1, ERR_BAD_OPER);
        check("errs_after_badoper", 64'(out_stat_errors), 64'd2);
        pop_one();
        send(3'd6, 1'b0, 4'd1, 4'd2, 4'd3, 4'd0, 64'd0);
        expect_head("badgroup", 32'hC1230000, 1'b1, ERR_BAD_GROUP);
        check("errs_after_badgroup", 64'(out_stat_errors), 64'd3);
        check("enc_after_6", 64'(out_stat_encoded), 64'd6);
        pop_one();

        // Backpressure: two fill the FIFO, third is held off
        send(3'd2, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 64'd5);
        send(3'd3, 1'b0, 4'd4, 4'd5, 4'd6, 4'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        set_fields(3'd2, 1'b0, 4'hF, 4'hF, 4'hF, 4'd8, 64'h7FF);
        in_valid = 1'b1;
        check("full_not_ready", 64'(in_ready), 64'd0);
        step();
        check("full_still_held", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        check("order_a", 64'(out_instr), 64'h41234005);
        step();
        check("order_b", 64'(out_instr), 64'h64567FFE);
        check("ready_after_pop", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("order_c", 64'(out_instr), 64'h4FFF87FF);
        check("order_c_valid", 64'(out_valid), 64'd1);
        step();
        check("drained", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
        check("enc_after_9", 64'(out_stat_encoded), 64'd9);

        // Flush with FIFO full
        send(3'd2, 1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 64'd1);
        send(3'd2, 1'b0, 4'd2, 4'd2, 4'd2, 4'd2, 64'd2);
        in_flush = 1'b1;
        check("flush_blocks_ready", 64'(in_ready), 64'd0);
        step();
        in_flush = 1'b0;
        check("flush_empty", 64'(out_valid), 64'd0);
        check("flush_keeps_stats", 64'(out_stat_encoded), 64'd11);

        // Clear wins over a same-cycle accept
        set_fields(3'd7, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0);
        in_valid = 1'b1; in_clr_stats = 1'b1;
        step();
        in_valid = 1'b0; in_clr_stats = 1'b0;
        check("clr_enc", 64'(out_stat_encoded), 64'd0);
        check("clr_err", 64'(out_stat_errors), 64'd0);
        pop_one();

        // Preload error counter to 16'hFFFE at full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 70000 && n_acc < 65534; i++) begin
            if (in_ready) n_acc++;
            step();
        end
        in_valid = 1'b0;
        check("preload_errs", 64'(out_stat_errors), 64'hFFFE);
        send(3'd7, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 64'd0);
        send(3'd0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd15, 64'd0);
        send(3'd1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 64'h10_0000);
        check("errs_saturate", 64'(out_stat_errors), 64'hFFFF);
        check("enc_count", 64'(out_stat_encoded), 64'h10001);
        step();
        out_ready = 1'b0;

        // Async reset mid-stream, then re-accept held bundle
        send(3'd4, 1'b0, 4'd3, 4'd3, 4'd3, 4'd3, 64'd3);
        set_fields(3'd0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd12, 64'hFFFF_FFFF_FFFF_F800);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_instr", 64'(out_instr), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd0);
        check("arst_enc",   64'(out_stat_encoded), 64'd0);
        check("arst_err",   64'(out_stat_errors), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rel_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        expect_head("reaccept", 32'h1123C800, 1'b0, ERR_NONE);
        check("reaccept_enc", 64'(out_stat_encoded), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
